move_input_encoder: RTL and testbench
=====================================

Name: move_input_encoder

Overview:
- Generates the move commands that gameController consumes on its dir input.
- Takes four raw direction push-buttons and one centre (new-game) button.
- Synchronises and debounces each button, detects presses, and issues exactly one direction command per press on a valid/ready handshake.
- Also produces a one-cycle new-game pulse that drives the game's rst input.

Parameters:
- DEBOUNCE_CYCLES, 50000: consecutive cycles a synchronised input must differ from its stable level before the stable level flips (1 ms at 50 MHz).
- CNT_W, 17: width of each debounce counter; must satisfy 2^CNT_W > max(DEBOUNCE_CYCLES, REPEAT_CYCLES).
- REPEAT_CYCLES, 100000: auto-repeat interval; used only when AUTO_REPEAT_EN is defined.

Ports:
- clk, input, 1: system clock.
- rst_n, input, 1: asynchronous active-low reset.
- btn_up, input, 1: raw asynchronous button, active high.
- btn_right, input, 1: raw asynchronous button, active high.
- btn_down, input, 1: raw asynchronous button, active high.
- btn_left, input, 1: raw asynchronous button, active high.
- btn_center, input, 1: raw asynchronous new-game button, active high.
- move_ready, input, 1: consumer accepts the offered command on a clk edge where move_valid=1 and move_ready=1.
- dir, output, 2: direction code. 2'b00=UP, 2'b01=RIGHT, 2'b10=DOWN, 2'b11=LEFT.
- move_valid, output, 1: command offered.
- new_game, output, 1: one-cycle pulse on a centre press.

Behaviour:
- Synchroniser: a 2-flop synchroniser per button (5 total).
- Debounce, per button:
  - Counter increments on each edge where the synced level differs from the stable level.
  - Counter clears on any edge where they are equal.
  - On the edge where the counter would reach DEBOUNCE_CYCLES, the stable level toggles and the counter clears.
- Press event: rising edge of a stable level (stable=1, previous stable=0). This is combinational from the registered stable levels.
- Latency: a raw level held high is first sampled at edge 1. Then:
  - stable=1 after edge DEBOUNCE_CYCLES+2;
  - move_valid=1 after edge DEBOUNCE_CYCLES+3.
- FSM states: IDLE, OFFER, RELEASE.
  - IDLE: on any direction press event, register dir=code, set move_valid=1, go to OFFER. Simultaneous presses use priority UP > RIGHT > DOWN > LEFT.
  - OFFER: dir and move_valid are held constant until an edge samples move_ready=1. On that edge move_valid<=0 and the FSM goes to RELEASE. Press events in OFFER are discarded.
  - RELEASE: stays here until all four direction stable levels are 0, then goes to IDLE. Press events in RELEASE are discarded, so there is exactly one command per press.
- dir retains its last value while move_valid=0.
- new_game:
  - Asserted for exactly one cycle on a centre press event, in any FSM state.
  - On the same edge it forces move_valid<=0 and state<=RELEASE, aborting any pending offer.
  - If a centre press and a direction press occur on the same edge, new_game wins and no command is issued.
- Reset (rst_n=0, asynchronous):
  - dir=2'b00, move_valid=0, new_game=0.
  - All sync flops, stable levels and counters = 0; state=IDLE.
  - Outputs drop immediately, including mid-OFFER.
- After reset release, a button already held debounces afresh and yields one press after DEBOUNCE_CYCLES+3 edges.
- No combinational path from any input to any output.

Optional Feature:
- Macro: AUTO_REPEAT_EN.
- Defined:
  - A repeat counter clears on entry to RELEASE.
  - It increments while exactly the last-issued direction's stable level remains 1 and all others are 0.
  - On reaching REPEAT_CYCLES, the FSM re-offers the same dir with move_valid=1 and goes to OFFER.
  - Any other direction level going high, or the last direction releasing, clears the counter with no repeat.
- Undefined: no repeat counter exists, and RELEASE behaves exactly as described above.

Test Plan:
1. DEBOUNCE_CYCLES=4, move_ready=1; btn_up held high from edge 1 -> move_valid=1 after edge 7 for exactly 1 cycle with dir=00; no further move_valid while held; after release and re-press, a new 1-cycle move_valid appears.
2. btn_left high for 3 cycles then low, repeated 5 times -> move_valid never asserts; dir stays 00.
3. btn_right and btn_down rise on the same cycle and are held -> a single move_valid with dir=01.
4. btn_left press with move_ready=0 for 5 cycles after valid, then 1 -> dir=11 and move_valid=1 held for 6 cycles, drop after the accepting edge; a btn_up press issued during OFFER produces no command.
5. btn_center pressed while in OFFER -> new_game=1 for exactly 1 cycle; move_valid=0 after the same edge; no command until all buttons are released and re-pressed.
6. rst_n pulsed low mid-OFFER while btn_down stays held -> move_valid=0 immediately; after release, move_valid with dir=10 arrives DEBOUNCE_CYCLES+3 edges later. With AUTO_REPEAT_EN and REPEAT_CYCLES=10, holding btn_down yields repeated valid pulses 10 cycles after each handshake.

Source files
------------

// File: rtl/move_input_encoder.sv
// Debounced push-button front end that issues one valid/ready direction command per press and a new-game pulse.
// Optional AUTO_REPEAT_EN macro re-offers a held direction every REPEAT_CYCLES cycles.
module move_input_encoder #(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int CNT_W           = 17,
  parameter int REPEAT_CYCLES   = 100000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       btn_up,
  input  logic       btn_right,
  input  logic       btn_down,
  input  logic       btn_left,
  input  logic       btn_center,
  input  logic       move_ready,
  output logic [1:0] dir,
  output logic       move_valid,
  output logic       new_game
);

  typedef enum logic [1:0] {IDLE, OFFER, RELEASE} state_t;

  localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  if (((1 << CNT_W) <= DEBOUNCE_CYCLES) || ((1 << CNT_W) <= REPEAT_CYCLES)) begin : g_bad_cnt_w
    $error("CNT_W too narrow for DEBOUNCE_CYCLES/REPEAT_CYCLES");
  end

  // Bit order: 0=up, 1=right, 2=down, 3=left, 4=center; index equals the dir code.
  logic [4:0]       raw;
  logic [4:0]       sync1;
  logic [4:0]       sync2;
  logic [4:0]       stable;
  logic [4:0]       stable_q;
  logic [4:0]       press;
  logic [CNT_W-1:0] db_cnt [5];
  state_t           state;
  logic [1:0]       press_code;

  assign raw   = {btn_center, btn_left, btn_down, btn_right, btn_up};
  assign press = stable & ~stable_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1    <= '0;
      sync2    <= '0;
      stable   <= '0;
      stable_q <= '0;
      for (int i = 0; i < 5; i++) db_cnt[i] <= '0;
    end else begin
      sync1    <= raw;
      sync2    <= sync1;
      stable_q <= stable;
      for (int i = 0; i < 5; i++) begin
        if (sync2[i] == stable[i]) begin
          db_cnt[i] <= '0;
        end else if (db_cnt[i] == DB_LAST) begin
          stable[i] <= ~stable[i];
          db_cnt[i] <= '0;
        end else begin
          db_cnt[i] <= db_cnt[i] + 1'b1;
        end
      end
    end
  end

  // Lowest index wins: UP > RIGHT > DOWN > LEFT.
  always_comb begin
    press_code = 2'd0;
    if (press[0])      press_code = 2'd0;
    else if (press[1]) press_code = 2'd1;
    else if (press[2]) press_code = 2'd2;
    else if (press[3]) press_code = 2'd3;
  end

`ifdef AUTO_REPEAT_EN
  localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYCLES - 1);
  logic [CNT_W-1:0] rep_cnt;
  logic             only_last_held;

  assign only_last_held = (stable[3:0] == (4'd1 << dir));
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      dir        <= 2'b00;
      move_valid <= 1'b0;
      new_game   <= 1'b0;
`ifdef AUTO_REPEAT_EN
      rep_cnt    <= '0;
`endif
    end else begin
      new_game <= press[4];
      if (press[4]) begin
        // New game aborts any pending offer and waits for all directions to be released.
        move_valid <= 1'b0;
        state      <= RELEASE;
`ifdef AUTO_REPEAT_EN
        rep_cnt    <= '0;
`endif
      end else begin
        case (state)
          IDLE: begin
            if (|press[3:0]) begin
              dir        <= press_code;
              move_valid <= 1'b1;
              state      <= OFFER;
            end
          end
          OFFER: begin
            if (move_ready) begin
              move_valid <= 1'b0;
              state      <= RELEASE;
`ifdef AUTO_REPEAT_EN
              rep_cnt    <= '0;
`endif
            end
          end
          RELEASE: begin
`ifdef AUTO_REPEAT_EN
            if (only_last_held) begin
              if (rep_cnt == REP_LAST) begin
                rep_cnt    <= '0;
                move_valid <= 1'b1;
                state      <= OFFER;
              end else begin
                rep_cnt <= rep_cnt + 1'b1;
              end
            end else begin
              rep_cnt <= '0;
              if (stable[3:0] == 4'b0000) state <= IDLE;
            end
`else
            if (stable[3:0] == 4'b0000) state <= IDLE;
`endif
          end
          default: begin
            move_valid <= 1'b0;
            state      <= IDLE;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_move_input_encoder.sv
// Randomised and directed bench for move_input_encoder against a per-cycle behavioural reference model.
module tb_move_input_encoder;

  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       btn_up = 1'b0, btn_right = 1'b0, btn_down = 1'b0, btn_left = 1'b0, btn_center = 1'b0;
  logic       move_ready = 1'b1;
  logic [1:0] dir;
  logic       move_valid;
  logic       new_game;

  int checks = 0;
  int failures = 0;
  int edge_no = 0;

  move_input_encoder #(.DEBOUNCE_CYCLES(D), .CNT_W(17), .REPEAT_CYCLES(10)) dut (
    .clk(clk), .rst_n(rst_n),
    .btn_up(btn_up), .btn_right(btn_right), .btn_down(btn_down),
    .btn_left(btn_left), .btn_center(btn_center),
    .move_ready(move_ready), .dir(dir), .move_valid(move_valid), .new_game(new_game)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_no++;

  // Reference model: raw -> 2-cycle delay -> "flip after D consecutive differing cycles";
  // command logic tracks whether an offer is outstanding and whether we wait for full release.
  bit [4:0] m_s1, m_s2, m_st, m_pst;
  int       m_run [5];
  bit       m_busy, m_lock, m_ng;
  bit [1:0] m_dir;

  always @(posedge clk or negedge rst_n) begin
    bit [4:0] pr;
    bit [4:0] rawv;
    if (!rst_n) begin
      m_s1 = '0; m_s2 = '0; m_st = '0; m_pst = '0;
      for (int i = 0; i < 5; i++) m_run[i] = 0;
      m_busy = 0; m_lock = 0; m_ng = 0; m_dir = 2'd0;
    end else begin
      rawv = {btn_center, btn_left, btn_down, btn_right, btn_up};
      pr = m_st & ~m_pst;
      m_ng = pr[4];
      if (pr[4]) begin
        m_busy = 0;
        m_lock = 1;
      end else if (m_busy) begin
        if (move_ready) begin
          m_busy = 0;
          m_lock = 1;
        end
      end else if (m_lock) begin
        if (m_st[3:0] == 4'd0) m_lock = 0;
      end else if (pr[3:0] != 4'd0) begin
        for (int i = 3; i >= 0; i--) if (pr[i]) m_dir = 2'(i);
        m_busy = 1;
      end
      m_pst = m_st;
      for (int i = 0; i < 5; i++) begin
        if (m_s2[i] != m_st[i]) begin
          m_run[i]++;
          if (m_run[i] == D) begin
            m_st[i] = ~m_st[i];
            m_run[i] = 0;
          end
        end else begin
          m_run[i] = 0;
        end
      end
      m_s2 = m_s1;
      m_s1 = rawv;
    end
  end

  int       vcyc = 0, vrise = 0, ngcnt = 0;
  bit       prev_v = 0;
  bit [1:0] last_dir = 2'd0;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (dir !== m_dir || move_valid !== m_busy || new_game !== m_ng) begin
        failures++;
        $display("FAIL model_cmp t=%0t dut dir=%0d vld=%0b ng=%0b, model dir=%0d vld=%0b ng=%0b",
                 $time, dir, move_valid, new_game, m_dir, m_busy, m_ng);
      end
      if (move_valid) begin
        vcyc++;
        last_dir = dir;
      end
      if (move_valid && !prev_v) vrise++;
      if (new_game) ngcnt++;
      prev_v = move_valid;
    end else begin
      prev_v = 0;
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic wait_valid(input string name, output int e);
    e = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (move_valid === 1'b1) begin
        e = edge_no;
        break;
      end
    end
    if (e < 0) chk({name, "_timeout"}, 0, 1);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic clear_counts();
    vcyc = 0; vrise = 0; ngcnt = 0;
  endtask

  initial begin
    int base, e, hold [5];
    bit lvl [5];

    #1;
    chk("reset_dir", int'(dir), 0);
    chk("reset_valid", int'(move_valid), 0);
    chk("reset_new_game", int'(new_game), 0);
    idle(3);
    rst_n = 1'b1;
    idle(3);

    // 1: single press, latency and one command per press
    clear_counts();
    move_ready = 1'b1;
    btn_up = 1'b1;
    base = edge_no;
    wait_valid("t1_valid", e);
    chk("t1_latency", e - base, D + 3);
    chk("t1_dir", int'(dir), 0);
    idle(20);
    chk("t1_one_cycle", vcyc, 1);
    btn_up = 1'b0;
    idle(15);
    btn_up = 1'b1;
    idle(20);
    btn_up = 1'b0;
    idle(15);
    chk("t1_repress", vrise, 2);

    // 2: bounces shorter than the debounce window
    clear_counts();
    for (int r = 0; r < 5; r++) begin
      btn_left = 1'b1;
      idle(3);
      btn_left = 1'b0;
      idle(3);
    end
    idle(10);
    chk("t2_no_valid", vrise, 0);
    chk("t2_dir_kept", int'(dir), 0);

    // 3: simultaneous right+down, priority to right
    clear_counts();
    btn_right = 1'b1;
    btn_down = 1'b1;
    idle(20);
    chk("t3_count", vrise, 1);
    chk("t3_dir", int'(last_dir), 1);
    btn_right = 1'b0;
    btn_down = 1'b0;
    idle(15);

    // 4: backpressure holds the offer; a press during OFFER is dropped
    clear_counts();
    move_ready = 1'b0;
    btn_left = 1'b1;
    wait_valid("t4_valid", e);
    btn_up = 1'b1;
    idle(5);
    move_ready = 1'b1;
    idle(1);
    chk("t4_dropped", int'(move_valid), 0);
    chk("t4_hold_cycles", vcyc, 6);
    chk("t4_dir", int'(last_dir), 3);
    idle(20);
    btn_left = 1'b0;
    btn_up = 1'b0;
    idle(15);
    chk("t4_no_extra", vrise, 1);

    // 5: centre press aborts a pending offer
    clear_counts();
    move_ready = 1'b0;
    btn_right = 1'b1;
    wait_valid("t5_valid", e);
    btn_center = 1'b1;
    e = -1;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (new_game === 1'b1) begin
        e = k;
        break;
      end
    end
    chk("t5_ng_seen", int'(e >= 0), 1);
    chk("t5_valid_dropped", int'(move_valid), 0);
    move_ready = 1'b1;
    idle(20);
    chk("t5_ng_pulses", ngcnt, 1);
    chk("t5_no_cmd_held", vrise, 1);
    btn_right = 1'b0;
    btn_center = 1'b0;
    idle(15);
    btn_up = 1'b1;
    idle(20);
    btn_up = 1'b0;
    idle(15);
    chk("t5_resume", vrise, 2);

    // 6: asynchronous reset mid-OFFER with button still held
    clear_counts();
    move_ready = 1'b0;
    btn_down = 1'b1;
    wait_valid("t6_valid", e);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_valid", int'(move_valid), 0);
    chk("t6_rst_dir", int'(dir), 0);
    @(negedge clk);
    rst_n = 1'b1;
    base = edge_no;
    wait_valid("t6_valid2", e);
    chk("t6_latency", e - base, D + 3);
    chk("t6_dir", int'(dir), 2);
    move_ready = 1'b1;
    idle(3);
    btn_down = 1'b0;
    idle(15);

    // Random phase: checked cycle by cycle against the model
    clear_counts();
    for (int i = 0; i < 5; i++) begin
      hold[i] = 0;
      lvl[i] = 0;
    end
    for (int c = 0; c < 4000; c++) begin
      for (int i = 0; i < 5; i++) begin
        if (hold[i] == 0) begin
          lvl[i] = (i == 4) ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 2) == 0);
          hold[i] = $urandom_range(1, 14);
        end
        hold[i]--;
      end
      btn_up = lvl[0];
      btn_right = lvl[1];
      btn_down = lvl[2];
      btn_left = lvl[3];
      btn_center = lvl[4];
      move_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    chk("rand_activity", int'(vrise > 0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
